// File: rtl/lstm_bram_pkg.sv
// lstm_bram_pkg: shared state encoding, default sizes and width helper
// for the banked LSTM operand buffer.
package lstm_bram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int DEPTH_DEF      = 96;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/bram_bank_1r1w.sv
// bram_bank_1r1w: one simple-dual-port bank, read-first, registered output.
// Storage is never reset; only the output register is.
module bram_bank_1r1w
    import lstm_bram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = clog2(DEPTH)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    // Non-blocking write above gives read-first on a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rd_data <= '0;
        else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/lstm_banked_bram_loader.sv
// lstm_banked_bram_loader: multi-bank operand buffer with a sequenced
// streamed load (auto write address, done/error flags) and a 1-cycle read port.
module lstm_banked_bram_loader
    import lstm_bram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = clog2(DEPTH),
    parameter int LEN_WIDTH  = clog2(DEPTH + 1),
    parameter int BANK_WIDTH = (NUM_BANKS > 1) ? clog2(NUM_BANKS) : 1
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [BANK_WIDTH-1:0] load_bank,
    input  logic [LEN_WIDTH-1:0]  load_len,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_err,
    input  logic                  rd_en,
    input  logic [BANK_WIDTH-1:0] rd_bank,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam logic [LEN_WIDTH-1:0]  MAX_LEN = LEN_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [BANK_WIDTH:0]   NB      = (BANK_WIDTH + 1)'(NUM_BANKS);

    state_t                r_state, w_next;
    logic [BANK_WIDTH-1:0] r_bank, r_rd_bank;
    logic [LEN_WIDTH-1:0]  r_len, r_cnt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_done, r_err, r_rd_valid, r_rd_oor;
    logic                  w_start, w_start_ok, w_fire, w_last, w_rd_ok;
    logic [DATA_WIDTH-1:0] w_q [NUM_BANKS];

    always_comb begin
        w_start    = load_start && (r_state != LOAD);
        w_start_ok = w_start && (load_len != '0) && (load_len <= MAX_LEN)
                     && ({1'b0, load_bank} < NB);
        w_fire     = (r_state == LOAD) && s_valid;
        w_last     = r_cnt == r_len - LEN_WIDTH'(1);
        w_rd_ok    = ({1'b0, rd_addr} < DEPTH_A) && ({1'b0, rd_bank} < NB);
        w_next     = r_state;
        if (r_state == LOAD) w_next = (w_fire && w_last) ? DONE : LOAD;
        else if (load_start) w_next = w_start_ok ? LOAD : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
            r_ptr  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_start) begin
                r_done <= 1'b0;
                r_err  <= !w_start_ok;
            end else if (w_fire && w_last) begin
                r_done <= 1'b1;
            end
            if (w_start_ok) begin
                r_bank <= load_bank;
                r_len  <= load_len;
                r_cnt  <= '0;
                r_ptr  <= '0;
            end else if (w_fire) begin
                r_cnt <= r_cnt + LEN_WIDTH'(1);
                r_ptr <= r_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    // Out-of-range flag travels with the bank select so the mux forces 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_bank  <= '0;
            r_rd_oor   <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_bank <= rd_bank;
                r_rd_oor  <= !w_rd_ok;
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        bram_bank_1r1w #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (DEPTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .i_wr_en  (w_fire && (r_bank == BANK_WIDTH'(b))),
            .i_wr_addr(r_ptr),
            .i_wr_data(s_data),
            .i_rd_en  (rd_en && w_rd_ok && (rd_bank == BANK_WIDTH'(b))),
            .i_rd_addr(rd_addr),
            .o_rd_data(w_q[b])
        );
    end

    assign s_ready   = r_state == LOAD;
    assign load_busy = r_state == LOAD;
    assign load_done = r_done;
    assign load_err  = r_err;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_oor ? '0 : w_q[r_rd_bank];

endmodule

// File: tb/tb_lstm_banked_bram_loader.sv
// tb_lstm_banked_bram_loader: table-driven start/error vectors plus hand
// sequences for streaming, backpressure, collision and reset; reads scoreboarded.
module tb_lstm_banked_bram_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic [1:0]  load_bank = '0;
    logic [6:0]  load_len = '0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready, load_busy, load_done, load_err;
    logic        rd_en = 1'b0;
    logic [1:0]  rd_bank = '0;
    logic [6:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        rd_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          bank;
        int          addr;
        logic [31:0] data;
    } rd_exp_t;
    rd_exp_t exp_q[$];

    typedef struct {
        logic [1:0] bank;
        logic [6:0] len;
        logic       busy;
        logic       done;
        logic       err;
    } vec_t;
    vec_t vecs[4];

    lstm_banked_bram_loader dut (
        .clk       (clk),
        .rst       (rst),
        .load_start(load_start),
        .load_bank (load_bank),
        .load_len  (load_len),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .load_busy (load_busy),
        .load_done (load_done),
        .load_err  (load_err),
        .rd_en     (rd_en),
        .rd_bank   (rd_bank),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [1:0] b, input logic [6:0] l);
        load_start = 1'b1;
        load_bank  = b;
        load_len   = l;
        tick();
        load_start = 1'b0;
    endtask

    task automatic rd(input int b, input int a, input logic [31:0] e);
        rd_en   = 1'b1;
        rd_bank = 2'(b);
        rd_addr = 7'(a);
        exp_q.push_back('{b, a, e});
        tick();
        rd_en = 1'b0;
    endtask

    task automatic stream(input int n, input int base, output int ready_cycles);
        ready_cycles = 0;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(base + i);
            if (s_ready) ready_cycles++;
            if (i == n - 1) chk1("done_before_last", load_done, 1'b0);
            tick();
        end
        s_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected actual=%0h expected=none", rd_data);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("rd b%0d a%0d", e.bank, e.addr), rd_data, e.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int rc, hs, cyc;
        logic fire;

        vecs[0] = '{2'd2, 7'd0,   1'b0, 1'b0, 1'b1};
        vecs[1] = '{2'd1, 7'd97,  1'b0, 1'b0, 1'b1};
        vecs[2] = '{2'd0, 7'd127, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{2'd3, 7'd1,   1'b1, 1'b0, 1'b0};

        // Reset values
        tick();
        tick();
        chk1("rst_s_ready", s_ready, 1'b0);
        chk1("rst_busy", load_busy, 1'b0);
        chk1("rst_done", load_done, 1'b0);
        chk1("rst_err", load_err, 1'b0);
        chk1("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 32'h0);
        rst = 1'b0;
        tick();

        // Full load of bank 2
        start(2'd2, 7'd96);
        chk1("full_busy", load_busy, 1'b1);
        chk1("full_ready", s_ready, 1'b1);
        stream(96, 0, rc);
        chk("full_ready_cycles", rc, 96);
        chk1("full_done", load_done, 1'b1);
        chk1("full_busy_end", load_busy, 1'b0);
        chk1("full_ready_end", s_ready, 1'b0);
        chk1("full_err", load_err, 1'b0);
        rd(2, 96, 32'h0);
        rd(2, 127, 32'h0);
        rd(2, 0, 32'd0);
        rd(2, 95, 32'd95);
        rd(2, 50, 32'd50);
        tick();
        tick();
        chk1("hold_rd_valid", rd_valid, 1'b0);
        chk("hold_rd_data", rd_data, 32'd50);

        // Start/error vectors, first applied from DONE
        for (int i = 0; i < 4; i++) begin
            start(vecs[i].bank, vecs[i].len);
            chk1($sformatf("vec%0d_busy", i), load_busy, vecs[i].busy);
            chk1($sformatf("vec%0d_done", i), load_done, vecs[i].done);
            chk1($sformatf("vec%0d_err", i), load_err, vecs[i].err);
        end
        // Minimum load: len 1 into bank 3
        stream(1, 32'hA5A5_0003, rc);
        chk1("min_done", load_done, 1'b1);
        chk1("min_busy", load_busy, 1'b0);

        // Backpressure: s_valid toggles, len 4 into bank 0
        start(2'd0, 7'd4);
        hs = 0;
        cyc = 0;
        while (hs < 4 && cyc < 20) begin
            s_valid = (cyc % 2) == 0;
            s_data  = 32'(100 + hs);
            fire    = s_valid && s_ready;
            chk1("bp_done_early", load_done, 1'b0);
            tick();
            if (fire) hs++;
            cyc++;
        end
        s_valid = 1'b0;
        chk("bp_handshakes", hs, 4);
        chk1("bp_done", load_done, 1'b1);
        chk1("bp_ready_end", s_ready, 1'b0);
        for (int a = 0; a < 4; a++) rd(0, a, 32'(100 + a));
        rd(3, 0, 32'hA5A5_0003);

        // Prefill bank 1, then reload with collision reads and an ignored start
        start(2'd1, 7'd8);
        stream(8, 200, rc);
        start(2'd1, 7'd8);
        for (int k = 0; k < 8; k++) begin
            s_valid    = 1'b1;
            s_data     = 32'(300 + k);
            load_start = k == 3;
            load_bank  = 2'd0;
            load_len   = 7'd2;
            rd_en      = 1'b1;
            if (k % 2 == 0) begin
                rd_bank = 2'd1;
                rd_addr = 7'(k);
                exp_q.push_back('{1, k, 32'(200 + k)});
            end else begin
                rd_bank = 2'd0;
                rd_addr = 7'(k % 4);
                exp_q.push_back('{0, k % 4, 32'(100 + k % 4)});
            end
            tick();
            load_start = 1'b0;
            rd_en      = 1'b0;
            chk1($sformatf("col_busy%0d", k), load_busy, k < 7);
            chk1($sformatf("col_done%0d", k), load_done, k == 7);
            chk1($sformatf("col_err%0d", k), load_err, 1'b0);
        end
        s_valid = 1'b0;
        for (int a = 0; a < 8; a++) rd(1, a, 32'(300 + a));
        tick();
        tick();

        // Reset mid-load of bank 2
        start(2'd2, 7'd20);
        stream(10, 500, rc);
        rst = 1'b1;
        #1;
        chk1("mid_rst_s_ready", s_ready, 1'b0);
        chk1("mid_rst_busy", load_busy, 1'b0);
        chk1("mid_rst_done", load_done, 1'b0);
        chk1("mid_rst_err", load_err, 1'b0);
        chk1("mid_rst_rd_valid", rd_valid, 1'b0);
        chk("mid_rst_rd_data", rd_data, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        start(2'd2, 7'd20);
        stream(20, 600, rc);
        chk("reload_ready_cycles", rc, 20);
        chk1("reload_done", load_done, 1'b1);
        for (int a = 0; a < 20; a++) rd(2, a, 32'(600 + a));
        rd(2, 20, 32'd20);
        rd(2, 95, 32'd95);
        tick();
        tick();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
